keypad_entry_buffer: RTL and testbench
======================================

KEYPAD_ENTRY_BUFFER -- requirements
Module: keypad_entry_buffer

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of stored/displayed digits (range 1..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 100_000_000, idle cycles before an incomplete entry is cleared; 0 disables timeout.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 key  in  4  raw keypad code: 1..9 = digits, 4'hB = '0', 4'hA = '*', 4'hC = '#', others invalid.
REQ-006 key_valid  in  1  one key event per cycle held high.
REQ-007 mask_en  in  1  when high, filled display slots show MASK_CODE instead of digit values.
REQ-008 disp_digits  out  4*NUM_DIGITS  display nibbles; slot 0 = bits [3:0] = most recent digit.
REQ-009 digit_count  out  $clog2(NUM_DIGITS+1)  number of digits currently held.
REQ-010 code  out  4*NUM_DIGITS  committed code, same slot ordering as disp_digits.
REQ-011 code_len  out  $clog2(NUM_DIGITS+1)  digit count of committed code.
REQ-012 code_valid  out  1  one-cycle pulse on commit.
REQ-013 key_reject  out  1  one-cycle pulse when a key event is ignored.
REQ-014 timeout  out  1  one-cycle pulse when entry is cleared by inactivity.

Function
REQ-015 Decode: 1..9 -> value, 4'hB -> 0; '*' = backspace; '#' = enter; any other code is invalid.
REQ-016 FSM states EMPTY (count 0), ENTRY (0<count<NUM_DIGITS), FULL (count = NUM_DIGITS); state follows count after every accepted event.
REQ-017 Digit in EMPTY/ENTRY: shift stored digits up one slot, new digit into slot 0, count+1; outputs updated on the same edge.
REQ-018 Digit in FULL: buffer unchanged, key_reject pulses.
REQ-019 '*' in ENTRY/FULL: shift digits down one slot, top slot becomes BLANK_CODE, count-1.
REQ-020 '*' in EMPTY: no change, key_reject pulses.
REQ-021 '#' in ENTRY/FULL: code <= stored digits (unused slots BLANK_CODE), code_len <= count, code_valid pulses for one cycle, buffer cleared to EMPTY on the same edge.
REQ-022 '#' in EMPTY: no commit, key_reject pulses.
REQ-023 Invalid code with key_valid: no change, key_reject pulses.
REQ-024 code/code_len hold their value until the next commit.
REQ-025 disp_digits: slot i shows BLANK_CODE 4'hF if i >= count; else MASK_CODE 4'hE when mask_en, else the digit; registered, mask_en effective the cycle after it changes.
REQ-026 Idle counter increments each cycle with count>0 and key_valid low; resets on any key_valid and while EMPTY.
REQ-027 When the idle counter reaches TIMEOUT_CYCLES-1, buffer clears to EMPTY and timeout pulses; key_valid in the same cycle takes priority and timeout does not fire.
REQ-028 At most one of code_valid, key_reject, timeout is high in any cycle.

Reset
REQ-029 On rst: state EMPTY, count 0, all slots BLANK_CODE, code all BLANK_CODE, code_len 0, code_valid/key_reject/timeout 0, idle counter 0.
REQ-030 rst asserted mid-entry discards the entry immediately; no code_valid or timeout pulse on release.

Structure
REQ-031 Shared package keypad_pkg holds key constants (KEY_STAR 4'hA, KEY_ZERO 4'hB, KEY_HASH 4'hC), BLANK_CODE, MASK_CODE and the FSM state enum.
REQ-032 One sub-module keypad_decode (combinational: key -> is_digit, digit value, is_backspace, is_enter, is_invalid); all state in keypad_entry_buffer.

Verification
REQ-033 NUM_DIGITS=4: keys 1,2,3 -> disp_digits 16'hF123, digit_count 3; then '#' -> code 16'hF123, code_len 3, code_valid one cycle, disp_digits 16'hFFFF.
REQ-034 Keys 1,2,3,4,5 -> disp_digits 16'h1234, key_reject on fifth key; '*' -> 16'hF123, count 3.
REQ-035 From reset: '*' and '#' -> key_reject each, no code_valid; key 4'hD -> key_reject, state unchanged.
REQ-036 TIMEOUT_CYCLES=10: key 7 then idle -> timeout pulses exactly 10 cycles after the key, disp_digits 16'hFFFF; key on cycle 9 restarts counter.
REQ-037 Keys 9,0 with mask_en=1 -> disp_digits 16'hFFEE, code on '#' = 16'hFF90.
REQ-038 rst pulse after keys 1,2 -> all outputs at reset values, no pulses; next key 5 -> 16'hFFF5.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry buffer: raw key codes, the display
// fill codes and the entry state encoding.
// Ports: none (package).
package keypad_pkg;

  localparam int unsigned NIBBLE_W = 4;

  // Raw keypad codes for the non-numeric keys and for digit zero
  localparam logic [NIBBLE_W-1:0] KEY_STAR = 4'hA;
  localparam logic [NIBBLE_W-1:0] KEY_ZERO = 4'hB;
  localparam logic [NIBBLE_W-1:0] KEY_HASH = 4'hC;

  // Nibble shown in an unused slot, and in a filled slot while masking
  localparam logic [NIBBLE_W-1:0] BLANK_CODE = 4'hF;
  localparam logic [NIBBLE_W-1:0] MASK_CODE  = 4'hE;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2
  } entry_state_e;

endpackage

// File: rtl/keypad_decode.sv
// Combinational classification of a raw keypad code.
// Ports:
//   key_i          raw 4-bit keypad code
//   is_digit_o     key is 0..9 (digit_o carries its value)
//   digit_o        decoded digit value, 0 when not a digit
//   is_backspace_o key is '*'
//   is_enter_o     key is '#'
//   is_invalid_o   any other code
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [NIBBLE_W-1:0] key_i,
  output logic                is_digit_o,
  output logic [NIBBLE_W-1:0] digit_o,
  output logic                is_backspace_o,
  output logic                is_enter_o,
  output logic                is_invalid_o
);

  always_comb begin
    is_digit_o     = 1'b0;
    digit_o        = '0;
    is_backspace_o = 1'b0;
    is_enter_o     = 1'b0;
    is_invalid_o   = 1'b0;
    case (key_i)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
        is_digit_o = 1'b1;
        digit_o    = key_i;
      end
      KEY_ZERO: is_digit_o     = 1'b1;
      KEY_STAR: is_backspace_o = 1'b1;
      KEY_HASH: is_enter_o     = 1'b1;
      default:  is_invalid_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad digit entry buffer with backspace, commit, display masking and an
// inactivity timeout that discards an unfinished entry.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   key           raw keypad code, qualified by key_valid
//   key_valid     one key event in this cycle
//   mask_en       show MASK_CODE instead of digit values on the display
//   disp_digits   registered display nibbles, slot 0 = most recent digit
//   digit_count   number of digits currently held
//   code          last committed code (unused slots BLANK_CODE)
//   code_len      digit count of the last committed code
//   code_valid    one-cycle pulse on commit
//   key_reject    one-cycle pulse when a key event is ignored
//   timeout       one-cycle pulse when the entry is cleared by inactivity
module keypad_entry_buffer
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [3:0]                          key,
  input  logic                                key_valid,
  input  logic                                mask_en,
  output logic [4*NUM_DIGITS-1:0]             disp_digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     digit_count,
  output logic [4*NUM_DIGITS-1:0]             code,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     code_len,
  output logic                                code_valid,
  output logic                                key_reject,
  output logic                                timeout
);

  localparam int unsigned DW         = NIBBLE_W * NUM_DIGITS;
  localparam int unsigned CNT_W      = $clog2(NUM_DIGITS + 1);
  localparam int unsigned IDLE_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned IDLE_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  entry_state_e state_q, state_d;

  logic [DW-1:0]     digits_q, digits_d;
  logic [DW-1:0]     disp_q, disp_d;
  logic [DW-1:0]     code_q, code_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  code_len_q, code_len_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              code_valid_q, code_valid_d;
  logic              key_reject_q, key_reject_d;
  logic              timeout_q, timeout_d;

  logic                is_digit, is_back, is_enter, is_invalid;
  logic [NIBBLE_W-1:0] digit_val;

  keypad_decode u_decode (
    .key_i          (key),
    .is_digit_o     (is_digit),
    .digit_o        (digit_val),
    .is_backspace_o (is_back),
    .is_enter_o     (is_enter),
    .is_invalid_o   (is_invalid)
  );

  // Event qualification against the current fill state
  logic is_empty, is_full;
  logic do_digit, do_back, do_enter, do_reject, do_timeout;

  assign is_empty   = (state_q == ST_EMPTY);
  assign is_full    = (state_q == ST_FULL);
  assign do_digit   = key_valid & is_digit & ~is_full;
  assign do_back    = key_valid & is_back & ~is_empty;
  assign do_enter   = key_valid & is_enter & ~is_empty;
  assign do_reject  = key_valid & (is_invalid | (is_digit & is_full) |
                                   ((is_back | is_enter) & is_empty));
  // A key in the same cycle wins over the inactivity clear
  assign do_timeout = TIMEOUT_EN & ~key_valid & ~is_empty &
                      (idle_q == IDLE_W'(IDLE_LAST));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next state tracks the digit count after each accepted event
  always_comb begin
    state_d = state_q;
    if (do_enter || do_timeout) begin
      state_d = ST_EMPTY;
    end else if (do_digit) begin
      state_d = (count_q == CNT_W'(NUM_DIGITS - 1)) ? ST_FULL : ST_ENTRY;
    end else if (do_back) begin
      state_d = (count_q == CNT_W'(1)) ? ST_EMPTY : ST_ENTRY;
    end
  end

  // Output / datapath next values
  always_comb begin
    digits_d     = digits_q;
    count_d      = count_q;
    code_d       = code_q;
    code_len_d   = code_len_q;
    code_valid_d = do_enter;
    key_reject_d = do_reject;
    timeout_d    = do_timeout;
    if (!TIMEOUT_EN || key_valid || is_empty || do_timeout) idle_d = '0;
    else                                                     idle_d = idle_q + IDLE_W'(1);

    if (do_enter || do_timeout) begin
      digits_d = {NUM_DIGITS{BLANK_CODE}};
      count_d  = '0;
      if (do_enter) begin
        code_d     = digits_q;
        code_len_d = count_q;
      end
    end else if (do_digit) begin
      digits_d = (digits_q << NIBBLE_W) | DW'(digit_val);
      count_d  = count_q + CNT_W'(1);
    end else if (do_back) begin
      // Drop the newest digit; the vacated top slot becomes blank
      digits_d = (digits_q >> NIBBLE_W) | (DW'(BLANK_CODE) << (DW - NIBBLE_W));
      count_d  = count_q - CNT_W'(1);
    end
  end

  // Display image derived from the next buffer contents
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_disp
    assign disp_d[NIBBLE_W*g +: NIBBLE_W] =
      (CNT_W'(g) >= count_d) ? BLANK_CODE :
      (mask_en ? MASK_CODE : digits_d[NIBBLE_W*g +: NIBBLE_W]);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q     <= {NUM_DIGITS{BLANK_CODE}};
      disp_q       <= {NUM_DIGITS{BLANK_CODE}};
      code_q       <= {NUM_DIGITS{BLANK_CODE}};
      count_q      <= '0;
      code_len_q   <= '0;
      idle_q       <= '0;
      code_valid_q <= 1'b0;
      key_reject_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      digits_q     <= digits_d;
      disp_q       <= disp_d;
      code_q       <= code_d;
      count_q      <= count_d;
      code_len_q   <= code_len_d;
      idle_q       <= idle_d;
      code_valid_q <= code_valid_d;
      key_reject_q <= key_reject_d;
      timeout_q    <= timeout_d;
    end
  end

  assign disp_digits = disp_q;
  assign digit_count = count_q;
  assign code        = code_q;
  assign code_len    = code_len_q;
  assign code_valid  = code_valid_q;
  assign key_reject  = key_reject_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Randomized and directed bench for keypad_entry_buffer against a queue-based
// reference model of the entry rules.
module tb_keypad_entry_buffer;

  localparam int unsigned ND = 4;
  localparam int unsigned TO = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key = 4'h0;
  logic        key_valid = 1'b0;
  logic        mask_en = 1'b0;
  logic [15:0] disp_digits;
  logic [2:0]  digit_count;
  logic [15:0] code;
  logic [2:0]  code_len;
  logic        code_valid;
  logic        key_reject;
  logic        timeout;

  keypad_entry_buffer #(.NUM_DIGITS(ND), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .key_valid   (key_valid),
    .mask_en     (mask_en),
    .disp_digits (disp_digits),
    .digit_count (digit_count),
    .code        (code),
    .code_len    (code_len),
    .code_valid  (code_valid),
    .key_reject  (key_reject),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: q[0] is the most recent digit
  int          q[$];
  logic [15:0] m_code;
  int          m_len;
  bit          m_valid, m_rej, m_to;
  int          idle_run;
  logic [15:0] m_disp;

  function automatic logic [15:0] image(input bit masked);
    logic [15:0] v;
    v = 16'hFFFF;
    for (int i = 0; i < q.size() && i < ND; i++)
      v[4*i +: 4] = masked ? 4'hE : 4'(q[i]);
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_code = 16'hFFFF;
    m_len = 0;
    m_valid = 0; m_rej = 0; m_to = 0;
    idle_run = 0;
    m_disp = 16'hFFFF;
  endtask

  task automatic model_step(input logic [3:0] k, input logic kv, input logic m);
    m_valid = 0; m_rej = 0; m_to = 0;
    if (kv) begin
      idle_run = 0;
      if ((k >= 4'h1 && k <= 4'h9) || k == 4'hB) begin
        if (q.size() == ND) m_rej = 1;
        else q.push_front((k == 4'hB) ? 0 : int'(k));
      end else if (k == 4'hA) begin
        if (q.size() == 0) m_rej = 1;
        else void'(q.pop_front());
      end else if (k == 4'hC) begin
        if (q.size() == 0) m_rej = 1;
        else begin
          m_code = image(1'b0);
          m_len = q.size();
          m_valid = 1;
          q.delete();
        end
      end else begin
        m_rej = 1;
      end
    end else if (q.size() > 0) begin
      idle_run++;
      if (idle_run == TO) begin
        q.delete();
        m_to = 1;
        idle_run = 0;
      end
    end else begin
      idle_run = 0;
    end
    m_disp = image(m);
  endtask

  task automatic compare_all(input string ctx);
    check_eq({ctx, "_disp"}, 32'(disp_digits), 32'(m_disp));
    check_eq({ctx, "_count"}, 32'(digit_count), 32'(q.size()));
    check_eq({ctx, "_code"}, 32'(code), 32'(m_code));
    check_eq({ctx, "_len"}, 32'(code_len), 32'(m_len));
    check_eq({ctx, "_valid"}, 32'(code_valid), 32'(m_valid));
    check_eq({ctx, "_reject"}, 32'(key_reject), 32'(m_rej));
    check_eq({ctx, "_timeout"}, 32'(timeout), 32'(m_to));
    check_eq({ctx, "_onepulse"}, 32'(int'(code_valid) + int'(key_reject) + int'(timeout) <= 1), 32'd1);
  endtask

  // Apply one cycle of inputs, then compare after the edge
  task automatic step(input logic [3:0] k, input logic kv, input logic m, input string ctx);
    key = k; key_valid = kv; mask_en = m;
    @(posedge clk); #1;
    model_step(k, kv, m);
    compare_all(ctx);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    compare_all("reset");
    check_eq("reset_disp_lit", 32'(disp_digits), 32'hFFFF);

    // Basic entry and commit
    step(4'h1, 1, 0, "a1"); step(4'h2, 1, 0, "a2"); step(4'h3, 1, 0, "a3");
    check_eq("a_disp_lit", 32'(disp_digits), 32'hF123);
    check_eq("a_count_lit", 32'(digit_count), 32'd3);
    step(4'hC, 1, 0, "a_enter");
    check_eq("a_code_lit", 32'(code), 32'hF123);
    check_eq("a_valid_lit", 32'(code_valid), 32'd1);
    check_eq("a_clear_lit", 32'(disp_digits), 32'hFFFF);
    step(4'h0, 0, 0, "a_after");
    check_eq("a_valid_drop", 32'(code_valid), 32'd0);

    // Overflow and backspace
    for (int d = 1; d <= 5; d++) step(4'(d), 1, 0, "b_key");
    check_eq("b_full_lit", 32'(disp_digits), 32'h1234);
    check_eq("b_rej_lit", 32'(key_reject), 32'd1);
    step(4'hA, 1, 0, "b_back");
    check_eq("b_back_lit", 32'(disp_digits), 32'hF123);
    check_eq("b_count_lit", 32'(digit_count), 32'd3);
    step(4'hC, 1, 0, "b_enter");

    // Rejections from empty
    step(4'hA, 1, 0, "c_star"); check_eq("c_star_rej", 32'(key_reject), 32'd1);
    step(4'hC, 1, 0, "c_hash"); check_eq("c_hash_valid", 32'(code_valid), 32'd0);
    step(4'hD, 1, 0, "c_inv");  check_eq("c_inv_rej", 32'(key_reject), 32'd1);
    check_eq("c_inv_count", 32'(digit_count), 32'd0);

    // Timeout after exactly TO idle cycles
    step(4'h7, 1, 0, "d_key");
    for (int c = 1; c <= TO; c++) step(4'h0, 0, 0, "d_idle");
    check_eq("d_to_lit", 32'(timeout), 32'd1);
    check_eq("d_disp_lit", 32'(disp_digits), 32'hFFFF);
    // A key on the would-be timeout cycle takes priority and restarts the count
    step(4'h7, 1, 0, "e_key");
    for (int c = 1; c < TO; c++) step(4'h0, 0, 0, "e_idle");
    step(4'h3, 1, 0, "e_key2");
    check_eq("e_no_to", 32'(timeout), 32'd0);
    for (int c = 1; c <= TO; c++) step(4'h0, 0, 0, "e_idle2");
    check_eq("e_to_lit", 32'(timeout), 32'd1);

    // Masked display
    step(4'h9, 1, 1, "f_9"); step(4'hB, 1, 1, "f_0");
    check_eq("f_mask_lit", 32'(disp_digits), 32'hFFEE);
    step(4'hC, 1, 1, "f_enter");
    check_eq("f_code_lit", 32'(code), 32'hFF90);

    // Reset mid-entry
    step(4'h1, 1, 0, "g_1"); step(4'h2, 1, 0, "g_2");
    key_valid = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    compare_all("g_async");
    @(posedge clk); #1;
    rst = 1'b0;
    step(4'h0, 0, 0, "g_idle");
    step(4'h5, 1, 0, "g_5");
    check_eq("g_5_lit", 32'(disp_digits), 32'hFFF5);

    // Randomized traffic with occasional long idle bursts
    for (int n = 0; n < 400; n++) begin
      int r;
      logic m;
      r = $urandom_range(0, 99);
      m = ($urandom_range(0, 3) == 0);
      if (r < 8) begin
        int len;
        len = $urandom_range(TO - 2, TO + 2);
        for (int c = 0; c < len; c++) step(4'h0, 0, m, "rnd_burst");
      end else if (r < 65) begin
        step(4'($urandom_range(0, 15)), 1, m, "rnd_key");
      end else begin
        step(4'($urandom_range(0, 15)), 0, m, "rnd_idle");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
